cdc_fifo_word_assembler: RTL and testbench
==========================================

Name: cdc_fifo_word_assembler

Overview:
Read-domain consumer of the cdc_fifo read port. It pops DATA_WIDTH-wide entries and packs WORD_BYTES of them little-endian into one wide word. The word is presented on a valid/ready stream with a byte-keep mask. A flush request emits a partially filled word, so downstream logic can drain a short burst.

Parameters:
DATA_WIDTH, 8, width of one FIFO entry (one lane)
WORD_BYTES, 4, lanes per output word; legal range 2..16

Ports:
clock  input  1  read-domain clock (same clock as the FIFO read side)
reset  input  1  synchronous, active-high reset
fifo_read_data  input  DATA_WIDTH  FIFO head entry; valid whenever fifo_empty=0
fifo_empty  input  1  FIFO empty flag
fifo_read_increment  output  1  pop strobe; advances the FIFO read pointer at the clock edge
flush  input  1  single-cycle request to emit the partial word
out_data  output  DATA_WIDTH*WORD_BYTES  assembled word; lane 0 holds the first popped entry
out_keep  output  WORD_BYTES  per-lane valid mask
out_valid  output  1  output word valid
out_ready  input  1  downstream accepts the word when out_valid=1 and out_ready=1

Behaviour:
- Reset values: out_valid=0, out_data=0, out_keep=0. Lane counter, accumulator and flush_pending are also cleared. Reset has priority over all other inputs. Any partial word is discarded. FIFO entries already popped are lost; this is acceptable.
- slot_free = !out_valid || out_ready. The output register may load in any cycle where slot_free=1.
- Pop rule:
  - fifo_read_increment = !fifo_empty && !(stall).
  - stall = !slot_free && (count==WORD_BYTES-1 || flush_pending).
  - fifo_read_increment is never asserted while fifo_empty=1. It is combinational from registered state and the input flags.
- A pop writes fifo_read_data into lane[count] of the accumulator, then count increments.
- Full word:
  - Trigger: pop with count==WORD_BYTES-1.
  - The output register loads {popped entry, accumulator} in the same edge.
  - out_keep = all ones, out_valid=1, count=0.
  - flush_pending is cleared.
  - Latency: the last entry popped at edge N appears with out_valid=1 after edge N.
- Flush:
  - flush=1 sets flush_pending.
  - Service condition: a cycle where (flush || flush_pending) && slot_free.
    - If count>0 or a pop occurs: emit the partial word, including any byte popped in that cycle.
    - In that case out_keep has ones in lanes 0..(count+pop-1). Unused lanes are zero.
    - Then count=0 and flush_pending=0.
    - If count=0 and there is no pop: flush_pending clears and nothing is emitted.
  - A pending flush blocks popping while the slot is busy. This keeps the flushed word's contents fixed at the time of the request.
  - flush during a full-word emission cycle: that cycle emits the full word, keep=all ones, and flush_pending clears. The flush is absorbed.
- Output hold: while out_valid=1 and out_ready=0, out_data and out_keep are stable.
- Back-to-back throughput: one entry per clock when FIFO data is available and out_ready=1. Full words emit every WORD_BYTES cycles with no bubble.
- count width: $clog2(WORD_BYTES). It wraps only through the explicit reset-to-0 on emission.
- Simultaneous out_ready handshake and new load: the old word is consumed and the new word is registered in the same edge.
- States, implicit in counters: ACCUMULATING (count>0), IDLE (count=0), HOLDING (out_valid=1 with out_ready=0). No separate encoded FSM is required.

Decomposition:
- Shared package cdc_fifo_pkg holds:
  - lane-count constant LANE_COUNT_WIDTH(WORD_BYTES) as a function;
  - keep-mask helper function keep_mask(n) returning the low n bits set.
- One natural sub-module: word_output_register. It is a valid/ready holding register holding data plus keep, with a load strobe and slot_free output.
- The assembler core (counter, accumulator, flush_pending, pop logic) stays in the top.

Test Plan:
1. FIFO preloaded with 0x11,0x22,0x33,0x44, out_ready=1 -> four consecutive pops; out_data=0x44332211, out_keep=4'b1111, out_valid for 1 cycle after the 4th pop.
2. Eight entries 0x01..0x08 with out_ready=0 after the first word -> pops stop after entry 0x07 (count=3). out_data stays 0x04030201 until out_ready=1. Then 0x08 pops and word 0x08070605 is emitted on the next edge.
3. Entries 0xAA,0xBB, then the FIFO goes empty, then flush pulse -> out_data=0x0000BBAA, out_keep=4'b0011 one edge after the flush; count returns to 0.
4. flush with count=0, FIFO empty -> no out_valid, flush_pending cleared. A subsequent 4-entry burst produces a normal full word.
5. flush asserted in the same cycle as the 4th pop -> one full word with keep=4'b1111; no extra empty or partial word follows.
6. reset asserted mid-word (count=2, out_valid=1) -> next cycle out_valid=0, out_keep=0, out_data=0, count=0. fifo_read_increment=0 during reset, and fifo_read_increment never asserts while fifo_empty=1, checked by an assertion throughout.

Source files
------------

// File: rtl/cdc_fifo_pkg.sv
// Shared helpers for the CDC FIFO read-side word assembler:
// lane counter sizing and the lane keep-mask builder.
package cdc_fifo_pkg;

    localparam int MAX_WORD_BYTES = 16;

    function automatic int LANE_COUNT_WIDTH(input int word_bytes);
        return (word_bytes <= 1) ? 1 : $clog2(word_bytes);
    endfunction

    // Low n bits set; n may reach MAX_WORD_BYTES for a completely filled word.
    function automatic logic [MAX_WORD_BYTES-1:0] keep_mask(input logic [4:0] n);
        logic [MAX_WORD_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_WORD_BYTES; i++) begin
            m[i] = (5'(i) < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/cdc_fifo_word_assembler_word_output_register.sv
// Single-entry holding register for the assembled word and its keep mask,
// presented on a valid/ready stream.
module word_output_register
    import cdc_fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int KEEP_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [KEEP_W-1:0] load_keep,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_valid,
    output logic              slot_free
);

    // Handshake: a word transfers on an edge where out_valid && out_ready.
    // Once raised, out_valid stays high and data/keep stay stable until that
    // transfer; a load may coincide with a transfer (consume old, register new).
    assign slot_free = !out_valid || out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_data  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= load_data;
            out_keep  <= load_keep;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cdc_fifo_word_assembler.sv
// Read-domain consumer of the CDC FIFO: packs DATA_WIDTH entries little-endian
// into WORD_BYTES-lane words, with flush to emit a partially filled word.
module cdc_fifo_word_assembler
    import cdc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_BYTES = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [DATA_WIDTH-1:0]          fifo_read_data,
    input  logic                           fifo_empty,
    output logic                           fifo_read_increment,
    input  logic                           flush,
    output logic [DATA_WIDTH*WORD_BYTES-1:0] out_data,
    output logic [WORD_BYTES-1:0]          out_keep,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int CW = LANE_COUNT_WIDTH(WORD_BYTES);
    localparam int WW = DATA_WIDTH * WORD_BYTES;
    localparam logic [CW-1:0] LAST_LANE = CW'(WORD_BYTES - 1);

    logic [CW-1:0]             count;
    logic [WW-1:0]             acc;
    logic                      flush_pending;

    logic                      slot_free;
    logic                      stall;
    logic                      pop;
    logic                      flush_req;
    logic                      full_emit;
    logic                      flush_emit;
    logic                      load;
    logic [4:0]                fill;
    logic [MAX_WORD_BYTES-1:0] mask_all;
    logic                      unused_mask_bits;
    logic [WW-1:0]             word_next;
    logic [WW-1:0]             load_data;
    logic [WORD_BYTES-1:0]     load_keep;

    always_comb begin
        // A pending flush freezes the partial word while the output slot is busy.
        stall      = !slot_free && (count == LAST_LANE || flush_pending);
        pop        = !reset && !fifo_empty && !stall;
        flush_req  = flush || flush_pending;
        full_emit  = pop && (count == LAST_LANE);
        flush_emit = !full_emit && flush_req && slot_free && (count != '0 || pop);
        load       = !reset && (full_emit || flush_emit);

        fill      = 5'(count) + 5'(pop);
        mask_all  = keep_mask(fill);
        load_keep = mask_all[WORD_BYTES-1:0];

        word_next = acc;
        if (pop) begin
            word_next[int'(count)*DATA_WIDTH +: DATA_WIDTH] = fifo_read_data;
        end

        load_data = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (load_keep[i]) begin
                load_data[i*DATA_WIDTH +: DATA_WIDTH] = word_next[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign unused_mask_bits    = ^mask_all;
    assign fifo_read_increment = pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            count         <= '0;
            acc           <= '0;
            flush_pending <= 1'b0;
        end else begin
            if (load) begin
                count <= '0;
                acc   <= '0;
            end else if (pop) begin
                count <= count + 1'b1;
                acc   <= word_next;
            end

            // Any serviced flush clears the request, even when nothing was buffered.
            if (load || (flush_req && slot_free)) begin
                flush_pending <= 1'b0;
            end else if (flush) begin
                flush_pending <= 1'b1;
            end
        end
    end

    word_output_register #(
        .DATA_W(WW),
        .KEEP_W(WORD_BYTES)
    ) u_out_reg (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .load_data(load_data),
        .load_keep(load_keep),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_keep (out_keep),
        .out_valid(out_valid),
        .slot_free(slot_free)
    );

endmodule

// File: tb/tb_cdc_fifo_word_assembler.sv
// Bench for cdc_fifo_word_assembler: directed scenarios then random traffic,
// checked cycle by cycle against a queue-based behavioural model.
module tb_cdc_fifo_word_assembler;

    localparam int DW = 8;
    localparam int WB = 4;
    localparam int WW = DW * WB;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] fifo_read_data;
    logic          fifo_empty;
    logic          fifo_read_increment;
    logic          flush;
    logic [WW-1:0] out_data;
    logic [WB-1:0] out_keep;
    logic          out_valid;
    logic          out_ready;

    int checks = 0;
    int errors = 0;

    // Bench-side FIFO contents, bytes buffered in the model's partial word,
    // and the expected byte stream still owed to the consumer.
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] acc_q[$];
    logic [DW-1:0] exp_q[$];

    bit            m_valid;
    logic [WW-1:0] m_data;
    logic [WB-1:0] m_keep;
    bit            m_pend;

    always #5 clock = ~clock;

    cdc_fifo_word_assembler #(
        .DATA_WIDTH(DW),
        .WORD_BYTES(WB)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .fifo_read_data     (fifo_read_data),
        .fifo_empty         (fifo_empty),
        .fifo_read_increment(fifo_read_increment),
        .flush              (flush),
        .out_data           (out_data),
        .out_keep           (out_keep),
        .out_valid          (out_valid),
        .out_ready          (out_ready)
    );

    task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] b);
        fifo_q.push_back(b);
    endtask

    // One clock: drive at the falling edge, sample and compare shortly after,
    // then advance the model to what the next rising edge should produce.
    task automatic step(input bit rst, input bit flsh, input bit rdy);
        bit            slot;
        bit            stall_m;
        bit            pop_m;
        bit            emit;
        logic [WW-1:0] word;
        @(negedge clock);
        reset          = rst;
        flush          = flsh;
        out_ready      = rdy;
        fifo_empty     = (fifo_q.size() == 0);
        fifo_read_data = fifo_empty ? 8'($urandom) : fifo_q[0];
        #2;
        slot  = !m_valid || rdy;
        pop_m = 1'b0;
        if (!rst) begin
            stall_m = !slot && (acc_q.size() == WB - 1 || m_pend);
            pop_m   = !fifo_empty && !stall_m;
        end
        check("pop", fifo_read_increment, pop_m);
        if (fifo_empty) check("pop_while_empty", fifo_read_increment, 0);
        check("out_valid", out_valid, m_valid);
        check("out_keep", out_keep, m_keep);
        check("out_data", out_data, m_data);

        if (!rst && out_valid && rdy) begin
            for (int i = 0; i < WB; i++) begin
                if (out_keep[i]) begin
                    if (exp_q.size() == 0) check("sb_extra_lane", out_keep[i], 0);
                    else check("sb_byte", out_data[i*DW +: DW], exp_q.pop_front());
                end
            end
        end

        if (rst) begin
            acc_q.delete();
            exp_q.delete();
            m_valid = 0;
            m_data  = '0;
            m_keep  = '0;
            m_pend  = 0;
        end else begin
            if (pop_m) begin
                acc_q.push_back(fifo_q[0]);
                exp_q.push_back(fifo_q[0]);
                void'(fifo_q.pop_front());
            end
            emit = (acc_q.size() == WB) || ((flsh || m_pend) && slot && acc_q.size() > 0);
            if (((flsh || m_pend) && slot) || emit) m_pend = 0;
            else if (flsh) m_pend = 1;
            if (emit) begin
                word = '0;
                for (int i = 0; i < acc_q.size(); i++) word[i*DW +: DW] = acc_q[i];
                m_data  = word;
                m_keep  = WB'((1 << acc_q.size()) - 1);
                m_valid = 1;
                acc_q.delete();
            end else if (rdy) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic after_edge();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        flush          = 1'b0;
        out_ready      = 1'b0;
        fifo_empty     = 1'b1;
        fifo_read_data = '0;
        m_valid        = 0;
        m_data         = '0;
        m_keep         = '0;
        m_pend         = 0;

        step(1, 0, 0);
        step(1, 0, 0);

        // Four-entry burst with a ready consumer.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        repeat (4) step(0, 0, 1);
        after_edge();
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 32'h4433_2211);
        check("t1_keep", out_keep, 4'b1111);
        step(0, 0, 1);

        // Back-pressure after the first word: popping stops with three entries buffered.
        for (int i = 1; i <= 8; i++) push(8'(i));
        repeat (10) step(0, 0, 0);
        after_edge();
        check("t2_hold_data", out_data, 32'h0403_0201);
        check("t2_fifo_left", fifo_q.size(), 1);
        step(0, 0, 1);
        after_edge();
        check("t2_second_word", out_data, 32'h0807_0605);
        step(0, 0, 1);

        // Short burst drained by flush.
        push(8'hAA); push(8'hBB);
        repeat (3) step(0, 0, 1);
        step(0, 1, 1);
        after_edge();
        check("t3_valid", out_valid, 1);
        check("t3_data", out_data, 32'h0000_BBAA);
        check("t3_keep", out_keep, 4'b0011);
        step(0, 0, 1);

        // Flush with nothing buffered emits nothing; a later burst is a normal word.
        step(0, 1, 1);
        after_edge();
        check("t4_no_word", out_valid, 0);
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        repeat (4) step(0, 0, 1);
        after_edge();
        check("t4_data", out_data, 32'hC4C3_C2C1);
        check("t4_keep", out_keep, 4'b1111);
        step(0, 0, 1);

        // Flush coinciding with the fourth pop is absorbed into the full word.
        push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
        repeat (3) step(0, 0, 1);
        step(0, 1, 1);
        after_edge();
        check("t5_keep", out_keep, 4'b1111);
        check("t5_data", out_data, 32'hD4D3_D2D1);
        repeat (2) step(0, 0, 1);
        after_edge();
        check("t5_no_extra", out_valid, 0);

        // Reset mid-word while a word is held.
        for (int i = 0; i < 6; i++) push(8'hE0 + 8'(i));
        repeat (6) step(0, 0, 0);
        push(8'hF0); push(8'hF1);
        step(1, 0, 0);
        after_edge();
        check("t6_valid", out_valid, 0);
        check("t6_keep", out_keep, 0);
        check("t6_data", out_data, 0);
        step(0, 0, 1);
        repeat (6) step(0, 0, 1);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) != 0 && fifo_q.size() < 8) push(8'($urandom));
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 7);
        end
        repeat (20) step(0, 1, 1);
        check("final_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
